// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 10240;
  localparam logic [31:0] OOB_PATTERN   = 32'hDEAD_BEEF;

  typedef logic       master_id_t;
  typedef logic [3:0] burst_cnt_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Sticky round-robin grant with bounded burst; holds the owner and burst count registers.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  master_id_t owner_q, owner_d;
  burst_cnt_t burst_q, burst_d;

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = (burst_q < burst_cnt_t'(MAX_BURST)) ? owner_q : ~owner_q;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

  // Every grant is accepted in the same cycle, so the grant alone drives the update.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (!gnt_valid) begin
      burst_d = '0;
    end else if (gnt_id == owner_q) begin
      burst_d = (burst_q == burst_cnt_t'(15)) ? burst_q : burst_q + burst_cnt_t'(1);
    end else begin
      owner_d = gnt_id;
      burst_d = burst_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      burst_q <= '0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-master Avalon-MM arbiter for the single-port SRAM, with 1-cycle read return.
// Optional SRAM_ARB_BOUNDS_CHECK_EN: out-of-range accesses are absorbed and flagged on err_oob.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic [DATA_W-1:0]   sram_writedata,
  input  logic [DATA_W-1:0]   sram_readdata
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  ,
  output logic                err_oob
`endif
);

  logic                req0, req1, gnt_valid, gnt_en;
  master_id_t          gnt_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_read, sel_write;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wdata, rd_data;
  logic                oob, acc_read;
  logic                rd_pend_q, rd_id_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  sram_arb_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // Outputs must read as idle while reset is held, even with requests pending.
  assign gnt_en = gnt_valid & reset_n;

  always_comb begin
    sel_addr  = m0_address;
    sel_read  = m0_read;
    sel_write = m0_write;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    if (gnt_id == 1'b1) begin
      sel_addr  = m1_address;
      sel_read  = m1_read;
      sel_write = m1_write;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
    end
  end

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  logic rd_oob_q, err_oob_q;
  assign oob     = 32'(sel_addr) >= DEPTH;
  assign rd_data = rd_oob_q ? DATA_W'(OOB_PATTERN) : sram_readdata;
  assign err_oob = err_oob_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_oob_q  <= 1'b0;
      err_oob_q <= 1'b0;
    end else begin
      if (acc_read) rd_oob_q <= oob;
      if (gnt_en && oob) err_oob_q <= 1'b1;
    end
  end
`else
  assign oob     = 1'b0;
  assign rd_data = sram_readdata;
`endif

  // A simultaneous read+write is a write.
  assign acc_read = gnt_en & sel_read & ~sel_write;

  assign m0_waitrequest  = ~(gnt_en & (gnt_id == 1'b0));
  assign m1_waitrequest  = ~(gnt_en & (gnt_id == 1'b1));
  assign sram_address    = sel_addr;
  assign sram_byteenable = sel_be;
  assign sram_writedata  = sel_wdata;
  assign sram_chipselect = gnt_en & ~oob;
  assign sram_write      = gnt_en & sel_write & ~oob;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_pend_q <= acc_read;
      if (acc_read) rd_id_q <= gnt_id;
      if (rd_pend_q && !rd_id_q) rdata0_q <= rd_data;
      if (rd_pend_q && rd_id_q) rdata1_q <= rd_data;
    end
  end

  assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
  assign m1_readdatavalid = rd_pend_q & rd_id_q;
  assign m0_readdata      = m0_readdatavalid ? rd_data : rdata0_q;
  assign m1_readdata      = m1_readdatavalid ? rd_data : rdata1_q;

  rw_both_m0: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
  rw_both_m1: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboarded bench for sram_port_arbiter with a behavioural SRAM and reference arbiter.
module tb_sram_port_arbiter;

  localparam int unsigned MAXB  = 4;
  localparam int unsigned DEPTH = 10240;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] sram_address;
  logic        sram_chipselect, sram_write;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_writedata;
  logic [31:0] sram_readdata;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  logic        err_oob;
`endif

  int errors = 0;
  int checks = 0;

  sram_port_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_byteenable   (m0_byteenable),
    .m0_writedata    (m0_writedata),
    .m0_waitrequest  (m0_waitrequest),
    .m0_readdata     (m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_byteenable   (m1_byteenable),
    .m1_writedata    (m1_writedata),
    .m1_waitrequest  (m1_waitrequest),
    .m1_readdata     (m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_writedata  (sram_writedata),
    .sram_readdata   (sram_readdata)
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
    ,
    .err_oob         (err_oob)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: registered address, readdata one cycle after a read.
  logic [31:0] sram_mem [0:16383];
  always @(posedge clk) begin
    if (sram_chipselect) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++)
          if (sram_byteenable[b]) sram_mem[sram_address][b*8 +: 8] <= sram_writedata[b*8 +: 8];
      end else begin
        sram_readdata <= sram_mem[sram_address];
      end
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  logic [31:0] ref_mem [0:16383];
  logic [31:0] q0[$], q1[$];
  logic        due0, due1;
  logic [31:0] last0, last1, exp_d;
  logic        mdl_owner;
  int unsigned mdl_burst;
  logic        r0, r1, gv, g, g_rd, g_wr, ob;
  logic [13:0] g_a;
  logic [3:0]  g_be;
  logic [31:0] g_wd;

  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete(); q1.delete();
      due0 = 1'b0; due1 = 1'b0; last0 = '0; last1 = '0;
      mdl_owner = 1'b0; mdl_burst = 0;
    end else begin
      checks++;
      if (m0_readdatavalid !== due0) begin
        errors++; $display("FAIL m0_rvalid: got %b want %b @%0t", m0_readdatavalid, due0, $time);
      end
      if (due0) begin
        exp_d = q0.pop_front(); last0 = exp_d;
      end
      checks++;
      if (m0_readdata !== last0) begin
        errors++; $display("FAIL m0_rdata: got %h want %h @%0t", m0_readdata, last0, $time);
      end
      checks++;
      if (m1_readdatavalid !== due1) begin
        errors++; $display("FAIL m1_rvalid: got %b want %b @%0t", m1_readdatavalid, due1, $time);
      end
      if (due1) begin
        exp_d = q1.pop_front(); last1 = exp_d;
      end
      checks++;
      if (m1_readdata !== last1) begin
        errors++; $display("FAIL m1_rdata: got %h want %h @%0t", m1_readdata, last1, $time);
      end

      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      gv = r0 | r1;
      if (r0 && r1) g = (mdl_burst < MAXB) ? mdl_owner : !mdl_owner;
      else g = r1;
      g_a  = g ? m1_address : m0_address;
      g_rd = g ? m1_read : m0_read;
      g_wr = g ? m1_write : m0_write;
      g_be = g ? m1_byteenable : m0_byteenable;
      g_wd = g ? m1_writedata : m0_writedata;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
      ob = (32'(g_a) >= DEPTH);
`else
      ob = 1'b0;
`endif
      checks++;
      if (m0_waitrequest !== !(gv && !g)) begin
        errors++; $display("FAIL m0_wait: got %b want %b @%0t", m0_waitrequest, !(gv && !g), $time);
      end
      checks++;
      if (m1_waitrequest !== !(gv && g)) begin
        errors++; $display("FAIL m1_wait: got %b want %b @%0t", m1_waitrequest, !(gv && g), $time);
      end
      checks++;
      if (sram_chipselect !== (gv && !ob)) begin
        errors++; $display("FAIL sram_cs: got %b want %b @%0t", sram_chipselect, gv && !ob, $time);
      end
      checks++;
      if (sram_write !== (gv && g_wr && !ob)) begin
        errors++; $display("FAIL sram_wr: got %b want %b @%0t", sram_write, gv && g_wr && !ob, $time);
      end

      due0 = 1'b0; due1 = 1'b0;
      if (gv) begin
        if (g_wr) begin
          if (!ob)
            for (int b = 0; b < 4; b++)
              if (g_be[b]) ref_mem[g_a][b*8 +: 8] = g_wd[b*8 +: 8];
        end else if (g_rd) begin
          exp_d = ob ? 32'hDEAD_BEEF : ref_mem[g_a];
          if (g) begin q1.push_back(exp_d); due1 = 1'b1; end
          else begin q0.push_back(exp_d); due0 = 1'b1; end
        end
        if (g == mdl_owner) mdl_burst = (mdl_burst == 15) ? 15 : mdl_burst + 1;
        else begin mdl_owner = g; mdl_burst = 1; end
      end else begin
        mdl_burst = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL rst_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest);
    end
    checks++;
    if (sram_chipselect !== 1'b0 || sram_write !== 1'b0) begin
      errors++; $display("FAIL rst_sram: cs=%b wr=%b want 0 0", sram_chipselect, sram_write);
    end
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 ||
        m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
      errors++; $display("FAIL rst_rd: v=%b%b d0=%h d1=%h want 00 0 0", m0_readdatavalid,
                         m1_readdatavalid, m0_readdata, m1_readdata);
    end
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
    checks++;
    if (err_oob !== 1'b0) begin
      errors++; $display("FAIL rst_err_oob: got %b want 0", err_oob);
    end
`endif
    idle_inputs();
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    next_cycle();
    m0_write = 1'b1; m0_address = 14'h0010; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL single_wr_wait: got %b want 0", m0_waitrequest);
    end
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1;
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1234_5678 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL single_rd: v0=%b d0=%h v1=%b want 1 12345678 0", m0_readdatavalid,
                         m0_readdata, m1_readdatavalid);
    end
  endtask

  task automatic test_byte_lanes();
    next_cycle();
    m1_write = 1'b1; m1_address = 14'h0011; m1_writedata = 32'hAABB_CCDD; m1_byteenable = 4'hF;
    next_cycle();
    m1_writedata = 32'h0000_1100; m1_byteenable = 4'b0010;
    next_cycle();
    m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hAABB_11DD) begin
      errors++; $display("FAIL byte_lanes: v=%b d=%h want 1 aabb11dd", m1_readdatavalid, m1_readdata);
    end
  endtask

  task automatic test_contention();
    int unsigned exp_m;
    do_reset();
    m0_read = 1'b1; m0_address = 14'h0010;
    m1_read = 1'b1; m1_address = 14'h0011;
    for (int i = 0; i < 16; i++) begin
      exp_m = (i / 4) % 2;
      @(negedge clk);
      checks++;
      if (m0_waitrequest !== exp_m[0] || m1_waitrequest !== !exp_m[0]) begin
        errors++; $display("FAIL contention[%0d]: wait=%b%b want %b%b", i, m0_waitrequest,
                           m1_waitrequest, exp_m[0], !exp_m[0]);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_burst_release();
    for (int i = 0; i < 10; i++) begin
      m0_read = 1'b1; m0_address = 14'(32'h30 + i);
      @(negedge clk);
      checks++;
      if (m0_waitrequest !== 1'b0) begin
        errors++; $display("FAIL burst_stream[%0d]: wait=%b want 0", i, m0_waitrequest);
      end
      next_cycle();
    end
    m1_read = 1'b1; m1_address = 14'h0010;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL burst_release: wait=%b%b want 10", m0_waitrequest, m1_waitrequest);
    end
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL burst_drop: m1 wait=%b want 0", m1_waitrequest);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  task automatic test_bounds();
    m0_read = 1'b1; m0_address = 14'd10240;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || sram_chipselect !== 1'b0) begin
      errors++; $display("FAIL oob_accept: wait=%b cs=%b want 0 0", m0_waitrequest, sram_chipselect);
    end
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEAD_BEEF || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_read: v=%b d=%h err=%b want 1 deadbeef 1", m0_readdatavalid,
                         m0_readdata, err_oob);
    end
    next_cycle();
    m1_write = 1'b1; m1_address = 14'd12000; m1_writedata = 32'h5555_AAAA;
    next_cycle();
    m1_write = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (sram_mem[12000] !== 32'h0 || err_oob !== 1'b1) begin
      errors++; $display("FAIL oob_write: mem=%h err=%b want 0 1", sram_mem[12000], err_oob);
    end
    next_cycle();
  endtask
`endif

  task automatic test_reset_mid_read();
    next_cycle();
    m1_read = 1'b1; m1_address = 14'h0011;
    next_cycle();
    m1_read = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0 ||
        m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || sram_chipselect !== 1'b0) begin
      errors++; $display("FAIL midrd_reset: v=%b%b d1=%h wait=%b%b cs=%b want 00 0 11 0",
                         m0_readdatavalid, m1_readdatavalid, m1_readdata, m0_waitrequest,
                         m1_waitrequest, sram_chipselect);
    end
    next_cycle();
    reset_n = 1'b1;
    m0_read = 1'b1; m0_address = 14'h0010;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL midrd_release: wait0=%b v1=%b want 0 0", m0_waitrequest,
                         m1_readdatavalid);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_drain();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL drain: pending q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_readdata = '0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_byte_lanes();
    test_contention();
    test_burst_release();
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_reset_mid_read();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single-port on-chip SRAM: 32-bit data, 14-bit word address, 10240 words.
- The SRAM registers its address and presents readdata one cycle after an accepted read.
- Shares the single SRAM port between a CPU data master (m0) and a DMA/peripheral master (m1).
- Uses sticky round-robin grant with a bounded burst length, and returns read data with a readdatavalid strobe.
- Sits between the interconnect masters and the SRAM s1 slave port.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 10240, number of implemented words.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- mN_address  in  ADDR_W  word address (N = 0, 1).
- mN_read  in  1  read request.
- mN_write  in  1  write request.
- mN_byteenable  in  DATA_W/8  byte lanes.
- mN_writedata  in  DATA_W  write data.
- mN_waitrequest  out  1  high = request not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata.
- sram_address  out  ADDR_W  to SRAM address.
- sram_chipselect  out  1  to SRAM chipselect.
- sram_write  out  1  to SRAM write.
- sram_byteenable  out  DATA_W/8  to SRAM byteenable.
- sram_writedata  out  DATA_W  to SRAM writedata.
- sram_readdata  in  DATA_W  from SRAM readdata, valid one cycle after an accepted read.

Behaviour:
- Request definition: reqN = mN_read | mN_write. If read and write are both high, the transfer is treated as a write and the read is ignored; a simulation assertion flags it.
- Grant is combinational from the requests and registered state (owner, burst_cnt).
  - Only one master requesting: grant it.
  - Both requesting: grant owner while burst_cnt < MAX_BURST; otherwise grant the other master.
- Waitrequest: granted master has waitrequest=0 and is accepted this cycle. Non-granted master has waitrequest=1 and must hold its request stable.
- SRAM drive: sram_* carries the granted master's signals. sram_chipselect = grant valid. sram_write = accepted write. With no grant, sram_chipselect=0, sram_write=0, address/data = m0 values (don't care).
- Registered updates on each accepted transfer:
  - Same master as owner: burst_cnt saturating +1.
  - Different master: owner <= granted, burst_cnt <= 1.
  - Idle cycle: burst_cnt <= 0, owner unchanged.
- Read return:
  - 1-bit pending register rd_pend and 1-bit rd_id capture an accepted read.
  - Next cycle: m[rd_id]_readdatavalid=1 and m[rd_id]_readdata = sram_readdata.
  - The other master's readdata is held at its last value and readdatavalid=0.
- Throughput: back-to-back reads are allowed every cycle with 1-cycle latency. Write then read to the same address on consecutive cycles returns the new data.
- Reset (reset_n low, any time including mid-transfer):
  - owner=0, burst_cnt=0, rd_pend=0, rd_id=0, readdata=0.
  - Both waitrequest=1, sram_chipselect=0, sram_write=0, readdatavalid=0.
  - An in-flight read is discarded with no valid strobe after release.
  - The first cycle after reset release arbitrates normally.
- MAX_BURST=1 gives pure alternation under contention.

Optional Feature:
- Macro: SRAM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A granted access with address >= DEPTH is accepted (waitrequest=0), but sram_chipselect=0.
  - Writes are dropped.
  - Reads return 32'hDEAD_BEEF with the normal 1-cycle readdatavalid.
  - Adds output err_oob (1 bit), sticky high until reset; reset value 0.
- Not defined: no check, no err_oob port; the address is passed through unmodified.

Decomposition:
- Package sram_arb_pkg:
  - DEPTH_DEFAULT and OOB_PATTERN (32'hDEAD_BEEF) constants.
  - typedef master_id_t (1 bit).
  - typedef burst_cnt_t (4 bits).
- Sub-module sram_arb_grant: combinational grant, owner/burst_cnt registers, grant-valid and granted-id outputs. The top level holds muxing and the read-return pipeline.

Test Plan:
- Single-master path: m0 writes 0x12345678 to addr 0x0010 with byteenable 4'b1111, then reads it next cycle -> m0_readdatavalid exactly 1 cycle after acceptance with 0x12345678; m1 sees no valid.
- Byte lanes: write 0xAABBCCDD, then byteenable 4'b0010 write of 0x00001100 -> read returns 0xAABB11DD.
- Contention, MAX_BURST=4: both masters request reads continuously -> grant pattern m0 x4, m1 x4, repeating; each readdatavalid is routed to the correct master, with no lost or duplicated strobes.
- Burst release: m1 idle, m0 streams 10 reads -> all 10 granted back-to-back; m1 then requests -> granted within at most 1 cycle once m0's burst_cnt >= MAX_BURST, or immediately if m0 drops its request.
- Reset mid-read: assert reset_n low the cycle after an accepted m1 read -> no readdatavalid, all outputs at reset values; after release, the first request is granted immediately.
- Bounds (macro defined): m0 reads address 10240 -> readdata 0xDEADBEEF, err_oob=1 and stays high; prior SRAM contents are unchanged after an m1 write to address 12000.
